// File: rtl/pc_sequencer.sv
// pc_sequencer: owns PC and IR and sequences the fetch/execute loop of the
// accumulator processor (IDLE -> FETCH <-> EXEC, with sticky HALT and FAULT).
//
// Handshakes:
//   Instruction fetch: IMemReq is high for every FETCH cycle and IMemAddr
//   always equals PC. A cycle counts as a transfer when IMemAck is sampled
//   high on a rising edge during FETCH; IMemData is captured into IR on that
//   edge. Exec completion: ExecDone sampled high during EXEC is a one-cycle
//   completion, and PCSrc/BranchTaken are used on that same edge.
//   IMemAck is ignored outside FETCH, ExecDone outside EXEC and Start outside IDLE.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          PC_STEP       = 2,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Start,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [15:0] IMemData,
  output logic [15:0] IR,
  output logic        IRValid,
  input  logic        ExecDone,
  input  logic [1:0]  PCSrc,
  input  logic        BranchTaken,
  output logic [15:0] PC,
  output logic        Halted,
  output logic        Fault,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [15:0]   pc_q, pc_next;
  logic [15:0]   ir_q, ir_next;
  logic [CW-1:0] tcnt, tcnt_next;
  logic [15:0]   pc_plus;
  logic [15:0]   br_off;

  assign pc_plus = pc_q + 16'(PC_STEP);
  // Branch offset is the signed IR byte scaled to a halfword distance.
  assign br_off  = {{7{ir_q[7]}}, ir_q[7:0], 1'b0};

  // State, PC, IR and timeout counter registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= 16'h0000;
      tcnt  <= '0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      ir_q  <= ir_next;
      tcnt  <= tcnt_next;
    end
  end

  // Next-state, next-PC, IR capture and fetch-timeout counting.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    ir_next    = ir_q;
    tcnt_next  = tcnt;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          state_next = S_FETCH;
          tcnt_next  = '0;
        end
      end
      S_FETCH: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (IMemAck) begin
          ir_next    = IMemData;
          state_next = S_EXEC;
        end else if (tcnt == CW'(FETCH_TIMEOUT - 1)) begin
          state_next = S_FAULT;
        end else begin
          tcnt_next = tcnt + CW'(1);
        end
      end
      S_EXEC: begin
        if (ExecDone) begin
          state_next = S_FETCH;
          tcnt_next  = '0;
          unique case (PCSrc)
            2'b00: pc_next = pc_plus;
            2'b01: pc_next = BranchTaken ? (pc_plus + br_off) : pc_plus;
            2'b10: pc_next = {pc_plus[15:14], ir_q[12:0], 1'b0};
            default: state_next = S_HALT;
          endcase
        end
      end
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  assign IMemReq   = (state == S_FETCH);
  assign IRValid   = (state == S_EXEC);
  assign Halted    = (state == S_HALT);
  assign Fault     = (state == S_FAULT);
  assign PC        = pc_q;
  assign IMemAddr  = pc_q;
  assign IR        = ir_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge; the reference PC model works
// from the architectural next-PC rules using plain integer arithmetic.
module tb_pc_sequencer;

  logic        CLK;
  logic        Reset_n;
  logic        Start;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemAck;
  logic [15:0] IMemData;
  logic [15:0] IR;
  logic        IRValid;
  logic        ExecDone;
  logic [1:0]  PCSrc;
  logic        BranchTaken;
  logic [15:0] PC;
  logic        Halted;
  logic        Fault;
  logic [2:0]  dbg_state;

  int tests;
  int fails;
  logic [15:0] model_pc;
  logic [15:0] model_ir;
  logic [15:0] exp_q[$];

  pc_sequencer dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .IR         (IR),
    .IRValid    (IRValid),
    .ExecDone   (ExecDone),
    .PCSrc      (PCSrc),
    .BranchTaken(BranchTaken),
    .PC         (PC),
    .Halted     (Halted),
    .Fault      (Fault),
    .dbg_state  (dbg_state)
  );

  // Clock: 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next-PC computed from the instruction-set rules.
  function automatic logic [15:0] ref_next_pc(input logic [15:0] pc, input logic [15:0] ir,
                                              input logic [1:0] src, input logic taken);
    int pcp;
    int off;
    pcp = (int'(pc) + 2) % 65536;
    off = int'(ir[7:0]);
    if (off >= 128) off = off - 256;
    case (src)
      2'd0: return 16'(pcp);
      2'd1: return taken ? 16'((pcp + off * 2 + 65536) % 65536) : 16'(pcp);
      2'd2: return 16'((pcp / 16384) * 16384 + int'(ir % 16'h2000) * 2);
      default: return pc;
    endcase
  endfunction

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n  = 1'b1;
    model_pc = 16'h0000;
    model_ir = 16'h0000;
  endtask

  // Pulse Start in IDLE; FETCH must follow on the next cycle.
  task automatic do_start();
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    chk("start_req", {15'd0, IMemReq}, 16'd1);
    chk("start_addr", IMemAddr, model_pc);
  endtask

  // Hold off the ack for 'stall' FETCH cycles, then return 'data'.
  task automatic do_fetch(input logic [15:0] data, input int stall);
    for (int i = 0; i < stall; i++) begin
      chk("fetch_req", {15'd0, IMemReq}, 16'd1);
      chk("fetch_addr", IMemAddr, model_pc);
      IMemData = 16'($urandom);
      @(negedge CLK);
    end
    IMemAck  = 1'b1;
    IMemData = data;
    exp_q.push_back(data);
    @(negedge CLK);
    IMemAck  = 1'b0;
    model_ir = exp_q.pop_front();
    chk("exec_irvalid", {15'd0, IRValid}, 16'd1);
    chk("exec_ir", IR, model_ir);
    chk("exec_fault", {15'd0, Fault}, 16'd0);
  endtask

  // Stay in EXEC for 'stall' cycles (ack noise ignored), then complete.
  task automatic do_exec(input logic [1:0] src, input logic taken, input int stall);
    for (int i = 0; i < stall; i++) begin
      IMemAck  = 1'($urandom);
      IMemData = 16'($urandom);
      PCSrc    = 2'($urandom);
      @(negedge CLK);
      chk("exec_hold_ir", IR, model_ir);
      chk("exec_hold_pc", PC, model_pc);
    end
    IMemAck     = 1'b0;
    ExecDone    = 1'b1;
    PCSrc       = src;
    BranchTaken = taken;
    @(negedge CLK);
    ExecDone = 1'b0;
    model_pc = ref_next_pc(model_pc, model_ir, src, taken);
    chk("next_pc", PC, model_pc);
    if (src != 2'd3) begin
      chk("next_req", {15'd0, IMemReq}, 16'd1);
      chk("next_addr", IMemAddr, model_pc);
    end
  endtask

  task automatic do_insn(input logic [15:0] ir, input logic [1:0] src, input logic taken);
    do_fetch(ir, 0);
    do_exec(src, taken, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset_n = 1'b0; Start = 1'b0; IMemAck = 1'b0; IMemData = 16'h0;
    ExecDone = 1'b0; PCSrc = 2'd0; BranchTaken = 1'b0;
    model_pc = 16'h0; model_ir = 16'h0;

    // Reset state
    @(negedge CLK);
    chk("rst_pc", PC, 16'h0000);
    chk("rst_req", {15'd0, IMemReq}, 16'd0);
    chk("rst_fault", {15'd0, Fault}, 16'd0);
    chk("rst_halt", {15'd0, Halted}, 16'd0);
    chk("rst_irvalid", {15'd0, IRValid}, 16'd0);
    chk("rst_ir", IR, 16'h0000);
    do_reset();
    @(negedge CLK);
    chk("idle_req", {15'd0, IMemReq}, 16'd0);
    do_start();

    // Sequential
    do_insn(16'h1234, 2'd0, 1'b0);
    chk("seq_pc", PC, 16'h0002);

    // Branch taken / not taken with offset -2 from PC=0010
    do_insn(16'h0008, 2'd2, 1'b0);
    chk("jmp_0010", PC, 16'h0010);
    do_insn(16'h00FE, 2'd1, 1'b1);
    chk("br_taken", PC, 16'h000E);
    do_insn(16'h0008, 2'd2, 1'b0);
    do_insn(16'h00FE, 2'd1, 1'b0);
    chk("br_not_taken", PC, 16'h0012);

    // Randomized instruction stream with random stalls
    for (int n = 0; n < 24; n++) begin
      do_fetch(16'($urandom), $urandom_range(0, 3));
      do_exec(2'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 3));
    end

    // Jump chain exercising the upper PC bits and wrap
    do_insn(16'h1FFF, 2'd2, 1'b0);
    chk("jmp_3ffe", PC, 16'h3FFE);
    do_insn(16'h0000, 2'd2, 1'b0);
    chk("jmp_4000", PC, 16'h4000);
    do_insn(16'h1FFF, 2'd2, 1'b0);
    do_insn(16'h0000, 2'd2, 1'b0);
    chk("jmp_8000", PC, 16'h8000);
    do_insn(16'h1FFF, 2'd2, 1'b0);
    chk("jmp_bffe", PC, 16'hBFFE);
    do_insn(16'h0000, 2'd2, 1'b0);
    do_insn(16'h1FFF, 2'd2, 1'b0);
    chk("jmp_fffe", PC, 16'hFFFE);
    do_insn(16'h0000, 2'd0, 1'b0);
    chk("seq_wrap", PC, 16'h0000);

    // Ack in the final allowed FETCH cycle
    do_insn(16'h0040, 2'd2, 1'b0);
    do_fetch(16'hA5A5, 14);
    do_exec(2'd0, 1'b0, 1);

    // Async reset mid-FETCH
    chk("pre_rst_pc", PC, 16'h0082);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("midrst_req", {15'd0, IMemReq}, 16'd0);
    chk("midrst_pc", PC, 16'h0000);
    chk("midrst_state", {13'd0, dbg_state}, 16'd0);
    @(negedge CLK);
    Reset_n  = 1'b1;
    model_pc = 16'h0000;
    @(negedge CLK);
    chk("midrst_idle_req", {15'd0, IMemReq}, 16'd0);

    // Fetch timeout
    do_start();
    for (int i = 0; i < 15; i++) begin
      chk("to_req", {15'd0, IMemReq}, 16'd1);
      @(negedge CLK);
    end
    chk("to_fault", {15'd0, Fault}, 16'd1);
    chk("to_req_off", {15'd0, IMemReq}, 16'd0);
    IMemAck = 1'b1; IMemData = 16'hDEAD;
    repeat (3) @(negedge CLK);
    IMemAck = 1'b0;
    chk("to_sticky", {15'd0, Fault}, 16'd1);
    chk("to_ir_kept", IR, 16'h0000);
    chk("to_irvalid", {15'd0, IRValid}, 16'd0);

    // Halt
    do_reset();
    do_start();
    do_insn(16'h0100, 2'd0, 1'b0);
    do_insn(16'h0200, 2'd3, 1'b0);
    chk("halt_flag", {15'd0, Halted}, 16'd1);
    chk("halt_pc", PC, 16'h0002);
    Start = 1'b1;
    repeat (2) @(negedge CLK);
    Start = 1'b0;
    chk("halt_sticky", {15'd0, Halted}, 16'd1);
    chk("halt_req", {15'd0, IMemReq}, 16'd0);
    chk("halt_pc_hold", PC, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
